screen_sequencer: RTL and testbench
===================================

Name: screen_sequencer

Overview:
- Top-level screen controller: runs the game flow TITLE -> PLAY -> RESULT -> TITLE.
- Picks which full-screen renderer (title, play-field, result sprite) drives the VGA RGB outputs.
- Applies frame-synchronous fade-out/fade-in between screens and issues a one-cycle game reset when entering PLAY.
- Sits between the per-screen renderers and the VGA DAC pins, on the VGA pixel clock.

Parameters:
- FADE_FRAMES, 2, frames per fade step (>=1); one full fade = 17 steps.
- RESULT_HOLD_FRAMES, 120, minimum frames the result screen is shown before start is accepted.

Ports:
- vga_clk  in  1  pixel clock, one DrawX increment per cycle.
- Reset  in  1  reset; one clock domain; asynchronous, active-high.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video, 0 = blanking.
- start  in  1  start key level (edge-detected internally).
- game_over  in  1  play logic reports end of game (level).
- game_win  in  1  valid with game_over; 1 = player won.
- title_rgb  in  12  {r,g,b} from title renderer.
- play_rgb  in  12  {r,g,b} from play renderer.
- result_rgb  in  12  {r,g,b} from result renderer.
- red  out  4  scaled red to DAC.
- green  out  4  scaled green to DAC.
- blue  out  4  scaled blue to DAC.
- screen_sel  out  2  0 = TITLE, 1 = PLAY, 2 = RESULT.
- fade_level  out  5  brightness 0..16.
- game_rst  out  1  one-cycle pulse when the play screen is switched in.
- result_win  out  1  latched game_win for the result renderer.
- busy  out  1  high during FADE_OUT/FADE_IN.

Behaviour:
- Reset (async): state=S_TITLE, screen_sel=0, fade_level=16, red/green/blue=0, game_rst=0, result_win=0, frame_cnt=0, hold_cnt=0, start edge register=0.
- frame_tick: one-cycle pulse on the cycle DrawX==0 && DrawY==0, qualified by a registered previous-match so exactly one pulse per frame.
- start_edge: start high this cycle, low last cycle.
- States: S_TITLE, S_PLAY, S_RESULT, S_FADE_OUT, S_FADE_IN. Register target holds the destination screen.
- S_TITLE + start_edge -> S_FADE_OUT, target=PLAY.
- S_PLAY + game_over -> S_FADE_OUT, target=RESULT, result_win<=game_win (same cycle). start is ignored in S_PLAY.
- S_RESULT:
  - hold_cnt is cleared on entry and increments per frame_tick, saturating at RESULT_HOLD_FRAMES.
  - start_edge while hold_cnt==RESULT_HOLD_FRAMES -> S_FADE_OUT, target=TITLE.
  - Earlier edges are dropped, not queued.
- Fade step: on frame_tick, frame_cnt increments. A step is due when frame_cnt==FADE_FRAMES-1; frame_cnt then returns to 0. frame_cnt is cleared on every fade-state entry.
- S_FADE_OUT step:
  - fade_level>0: decrement.
  - fade_level==0: screen_sel<=target, go to S_FADE_IN. If target==PLAY, assert game_rst for exactly that cycle.
- S_FADE_IN step:
  - fade_level<16: increment.
  - fade_level==16: enter the state matching screen_sel.
- Fade timing: each fade direction takes 17 steps = 17*FADE_FRAMES frame_ticks. fade_level and screen_sel change only on frame_tick cycles, so there is no mid-frame tearing.
- Inputs ignored while busy: start and game_over are ignored in both fade states. A game_over still high on PLAY entry triggers the next transition on the following cycle.
- RGB path: src = mux(screen_sel) of the three rgb inputs. Each channel = (src_ch * fade_level) >> 4 using an 8-bit intermediate.
  - fade_level=16 gives passthrough; 0 gives black.
  - Outputs are registered with 1 vga_clk latency, and forced to 0 when blank==0 (registered in the same stage).
- Reset mid-fade: returns immediately to reset values; no game_rst pulse is emitted.

Decomposition:
- Package screen_pkg:
  - screen_t enum (SCR_TITLE=0, SCR_PLAY=1, SCR_RESULT=2).
  - state_t enum of the five states.
  - FADE_MAX=16.
- Sub-module fade_scaler: combinational, one 4-bit channel x 5-bit level -> 4-bit output, instantiated three times.
- The FSM, counters, tick/edge detect and output register stay in screen_sequencer.

Test Plan:
- Reset + 3 frames, title_rgb=12'hF84 -> screen_sel=0, fade_level=16, RGB=F,8,4 one cycle after blank=1; RGB=0 while blank=0.
- FADE_FRAMES=1, start pulse in TITLE:
  - fade_level 16..0 over 16 ticks, then screen_sel=1 plus a single-cycle game_rst on tick 17.
  - fade_level back to 16 by tick 33, then busy=0, state PLAY.
  - Mid-fade at fade_level=8, channel 4'hF outputs 4'h7.
- In PLAY, game_over=1 with game_win=1 and start=1 together -> fade to RESULT, result_win=1, start not acted on.
- RESULT_HOLD_FRAMES=4:
  - start edge at hold_cnt=2 -> ignored, stays RESULT.
  - start edge at hold_cnt=4 -> fades to TITLE; game_rst stays 0.
- start held high continuously across the TITLE->PLAY fade and into PLAY -> no second transition (edge only); game_over toggled during the fade is ignored.
- Assert Reset at fade_level=5 during FADE_OUT -> next cycle screen_sel=0, fade_level=16, busy=0, RGB=0, no game_rst.

Source files
------------

// File: rtl/screen_sequencer_pkg.sv
// Shared types for the screen sequencer: screen identifiers, FSM states and
// the full-brightness fade level.
package screen_pkg;

  localparam int FADE_MAX = 16;

  typedef enum logic [1:0] {
    SCR_TITLE  = 2'd0,
    SCR_PLAY   = 2'd1,
    SCR_RESULT = 2'd2
  } screen_t;

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_PLAY     = 3'd1,
    S_RESULT   = 3'd2,
    S_FADE_OUT = 3'd3,
    S_FADE_IN  = 3'd4
  } state_t;

endpackage

// File: rtl/screen_sequencer_fade_scaler.sv
// One colour channel scaled by a brightness level 0..16:
// out = (ch * level) >> 4. Level 16 passes the channel through, 0 is black.
module fade_scaler (
  input  logic [3:0] ch_i,
  input  logic [4:0] level_i,
  output logic [3:0] ch_o
);

  logic [7:0] prod;

  // 15 * 16 = 240 is the largest product, so 8 bits never overflow.
  always_comb begin
    prod = {4'b0000, ch_i} * {3'b000, level_i};
    ch_o = prod[7:4];
  end

endmodule

// File: rtl/screen_sequencer.sv
// Top-level screen controller. Runs TITLE -> PLAY -> RESULT -> TITLE with a
// frame-synchronous fade-out / fade-in between screens, selects which
// renderer drives the DAC and scales its colour by the current fade level.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int FADE_FRAMES        = 2,
  parameter int RESULT_HOLD_FRAMES = 120
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        start,
  input  logic        game_over,
  input  logic        game_win,
  input  logic [11:0] title_rgb,
  input  logic [11:0] play_rgb,
  input  logic [11:0] result_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [1:0]  screen_sel,
  output logic [4:0]  fade_level,
  output logic        game_rst,
  output logic        result_win,
  output logic        busy,
  output state_t      dbg_state
);

  localparam int CW = 16;

  logic          origin_d, origin_q;
  logic          start_q;
  logic          frame_tick, start_edge, step_due;
  state_t        state_q;
  screen_t       target_q, screen_q;
  logic [4:0]    level_q;
  logic [CW-1:0] frame_cnt_q, hold_cnt_q;
  logic          game_rst_q, result_win_q;
  logic [11:0]   src_rgb;
  logic [3:0]    red_s, green_s, blue_s;

  assign origin_d   = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign frame_tick = origin_d && !origin_q;
  assign start_edge = start && !start_q;
  assign step_due   = frame_tick && (frame_cnt_q == CW'(FADE_FRAMES - 1));

  // Previous-cycle copies for the frame-origin pulse and start edge detect.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      origin_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      origin_q <= origin_d;
      start_q  <= start;
    end
  end

  // Game-flow FSM with its fade level, screen select, counters and pulses.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_TITLE;
      target_q     <= SCR_TITLE;
      screen_q     <= SCR_TITLE;
      level_q      <= 5'(FADE_MAX);
      frame_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      game_rst_q   <= 1'b0;
      result_win_q <= 1'b0;
    end else begin
      game_rst_q <= 1'b0;
      case (state_q)
        S_TITLE: begin
          if (start_edge) begin
            state_q     <= S_FADE_OUT;
            target_q    <= SCR_PLAY;
            frame_cnt_q <= '0;
          end
        end
        S_PLAY: begin
          if (game_over) begin
            state_q      <= S_FADE_OUT;
            target_q     <= SCR_RESULT;
            result_win_q <= game_win;
            frame_cnt_q  <= '0;
          end
        end
        S_RESULT: begin
          // Edges before the hold expires are simply dropped.
          if (start_edge && (hold_cnt_q == CW'(RESULT_HOLD_FRAMES))) begin
            state_q     <= S_FADE_OUT;
            target_q    <= SCR_TITLE;
            frame_cnt_q <= '0;
          end else if (frame_tick && (hold_cnt_q < CW'(RESULT_HOLD_FRAMES))) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        S_FADE_OUT: begin
          if (step_due) begin
            frame_cnt_q <= '0;
            if (level_q != 5'd0) begin
              level_q <= level_q - 5'd1;
            end else begin
              // Screen swaps only while fully black, on a frame boundary.
              screen_q <= target_q;
              state_q  <= S_FADE_IN;
              if (target_q == SCR_PLAY) game_rst_q <= 1'b1;
            end
          end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
        end
        S_FADE_IN: begin
          if (step_due) begin
            frame_cnt_q <= '0;
            if (level_q != 5'(FADE_MAX)) begin
              level_q <= level_q + 5'd1;
            end else begin
              hold_cnt_q <= '0;
              case (screen_q)
                SCR_PLAY:   state_q <= S_PLAY;
                SCR_RESULT: state_q <= S_RESULT;
                default:    state_q <= S_TITLE;
              endcase
            end
          end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_TITLE;
      endcase
    end
  end

  // Pick the renderer that owns the currently selected screen.
  always_comb begin
    case (screen_q)
      SCR_PLAY:   src_rgb = play_rgb;
      SCR_RESULT: src_rgb = result_rgb;
      default:    src_rgb = title_rgb;
    endcase
  end

  fade_scaler u_scale_r (.ch_i(src_rgb[11:8]), .level_i(level_q), .ch_o(red_s));
  fade_scaler u_scale_g (.ch_i(src_rgb[7:4]),  .level_i(level_q), .ch_o(green_s));
  fade_scaler u_scale_b (.ch_i(src_rgb[3:0]),  .level_i(level_q), .ch_o(blue_s));

  // DAC output register; blanking forces black in the same stage.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else if (!blank) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
    end else begin
      red   <= red_s;
      green <= green_s;
      blue  <= blue_s;
    end
  end

  assign screen_sel = screen_q;
  assign fade_level = level_q;
  assign game_rst   = game_rst_q;
  assign result_win = result_win_q;
  assign busy       = (state_q == S_FADE_OUT) || (state_q == S_FADE_IN);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer on a tiny 16x4 raster (64 cycles per frame).
// Expected fade levels come from the tick count since the fade started;
// expected colours from integer arithmetic on the driven renderer values.
module tb_screen_sequencer;
  import screen_pkg::*;

  localparam int LINE = 16;
  localparam int ROWS = 4;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, start, game_over, game_win;
  logic [11:0] title_rgb, play_rgb, result_rgb;
  logic [3:0]  red, green, blue;
  logic [1:0]  screen_sel;
  logic [4:0]  fade_level;
  logic        game_rst, result_win, busy;
  state_t      dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int rx = 0, ry = 0;
  bit ticked;
  bit go_noise = 0;
  logic drv_blank;
  int rst_seen = 0;

  screen_sequencer #(.FADE_FRAMES(1), .RESULT_HOLD_FRAMES(4)) dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .start(start), .game_over(game_over), .game_win(game_win),
    .title_rgb(title_rgb), .play_rgb(play_rgb), .result_rgb(result_rgb),
    .red(red), .green(green), .blue(blue), .screen_sel(screen_sel),
    .fade_level(fade_level), .game_rst(game_rst), .result_win(result_win),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 vga_clk = ~vga_clk;

  // Watchdog.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference colour: each channel times level, divided by 16; black in blanking.
  function automatic logic [11:0] model_rgb(logic [11:0] src, int lvl, logic bl);
    int r, g, b;
    if (!bl) return 12'h000;
    r = int'(src[11:8]) * lvl / 16;
    g = int'(src[7:4]) * lvl / 16;
    b = int'(src[3:0]) * lvl / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  // Reference fade level k ticks after a fade started (one tick per step).
  function automatic int fade_lvl(int k);
    if (k <= 16) return 16 - k;
    if (k <= 33) return k - 17;
    return 16;
  endfunction

  // Driver: advance the raster one pixel, clock once, settle past the edge.
  task automatic step();
    @(negedge vga_clk);
    if (go_noise) game_over = 1'($urandom_range(0, 1));
    rx++;
    if (rx == LINE) begin
      rx = 0;
      ry = (ry + 1) % ROWS;
    end
    DrawX = 10'(rx);
    DrawY = 10'(ry);
    blank = (rx < 12);
    drv_blank = blank;
    @(posedge vga_clk);
    #1;
    ticked = (rx == 0 && ry == 0);
    if (game_rst === 1'b1) rst_seen++;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    ticked = 0;
    while (!ticked && n < 200) begin
      step();
      n++;
    end
    if (!ticked) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no frame tick within 200 cycles", tag);
    end
  endtask

  // One complete fade-out/fade-in, checking level, screen, busy and colour.
  task automatic run_fade(input logic [1:0] from_sel, input logic [1:0] to_sel,
                          input int exp_pulses, input string tag);
    logic [11:0] src, exp;
    logic [1:0]  s;
    rst_seen = 0;
    for (int k = 1; k <= 34; k++) begin
      if (go_noise && k >= 30) begin
        go_noise = 0;
        game_over = 1'b0;
      end
      wait_tick(tag);
      s = (k < 17) ? from_sel : to_sel;
      vectors++;
      if (fade_level !== 5'(fade_lvl(k))) begin
        miscompares++;
        $display("FAIL %s level tick %0d: got %0d want %0d", tag, k, fade_level, fade_lvl(k));
      end
      vectors++;
      if (screen_sel !== s) begin
        miscompares++;
        $display("FAIL %s screen_sel tick %0d: got %0d want %0d", tag, k, screen_sel, s);
      end
      vectors++;
      if (busy !== (k < 34)) begin
        miscompares++;
        $display("FAIL %s busy tick %0d: got %0b want %0b", tag, k, busy, (k < 34));
      end
      if (k == 17) begin
        vectors++;
        if (game_rst !== (exp_pulses == 1)) begin
          miscompares++;
          $display("FAIL %s game_rst at swap: got %0b want %0b", tag, game_rst, (exp_pulses == 1));
        end
      end
      for (int v = 0; v < 2; v++) begin
        title_rgb  = 12'($urandom);
        play_rgb   = 12'($urandom);
        result_rgb = 12'($urandom);
        step();
        src = (s == 2'd0) ? title_rgb : (s == 2'd1) ? play_rgb : result_rgb;
        exp = model_rgb(src, fade_lvl(k), drv_blank);
        vectors++;
        if ({red, green, blue} !== exp) begin
          miscompares++;
          $display("FAIL %s rgb tick %0d: got %h want %h", tag, k, {red, green, blue}, exp);
        end
      end
    end
    vectors++;
    if (rst_seen !== exp_pulses) begin
      miscompares++;
      $display("FAIL %s game_rst pulses: got %0d want %0d", tag, rst_seen, exp_pulses);
    end
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    Reset = 1'b1; start = 0; game_over = 0; game_win = 0;
    title_rgb = 12'hF84; play_rgb = 12'h0F0; result_rgb = 12'h00F;
    DrawX = 0; DrawY = 0; blank = 0; rx = 0; ry = 0;
    repeat (3) step();
    vectors++;
    if ({screen_sel, fade_level, busy, game_rst, result_win} !== {2'd0, 5'd16, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_values: got sel=%0d lvl=%0d busy=%0b rst=%0b win=%0b want 0,16,0,0,0",
               screen_sel, fade_level, busy, game_rst, result_win);
    end
    vectors++;
    if ({red, green, blue} !== 12'h000 || dbg_state !== S_TITLE) begin
      miscompares++;
      $display("FAIL reset_rgb_state: got rgb=%h state=%0d want 000 S_TITLE", {red, green, blue}, dbg_state);
    end
    Reset = 1'b0;
    for (int i = 0; i < 3 * LINE * ROWS; i++) begin
      step();
      exp = drv_blank ? 12'hF84 : 12'h000;
      vectors++;
      if ({red, green, blue} !== exp) begin
        miscompares++;
        $display("FAIL title_passthrough cycle %0d: got %h want %h", i, {red, green, blue}, exp);
      end
    end
    vectors++;
    if (screen_sel !== 2'd0 || fade_level !== 5'd16 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL title_idle: got sel=%0d lvl=%0d busy=%0b want 0,16,0", screen_sel, fade_level, busy);
    end
  endtask

  task automatic test_fade_to_play();
    start = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_accepted: got busy=%0b want 1", busy);
    end
    go_noise = 1;
    run_fade(2'd0, 2'd1, 1, "title_to_play");
    // start stays held: no further transition may happen.
    for (int f = 0; f < 3; f++) begin
      wait_tick("play_hold");
      vectors++;
      if (screen_sel !== 2'd1 || busy !== 1'b0 || dbg_state !== S_PLAY) begin
        miscompares++;
        $display("FAIL play_stable frame %0d: got sel=%0d busy=%0b state=%0d want 1,0,S_PLAY",
                 f, screen_sel, busy, dbg_state);
      end
    end
  endtask

  task automatic test_play_to_result();
    start = 1'b0;
    step();
    game_over = 1'b1; game_win = 1'b1; start = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b1 || result_win !== 1'b1 || screen_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL game_over_accept: got busy=%0b win=%0b sel=%0d want 1,1,1", busy, result_win, screen_sel);
    end
    game_over = 1'b0; game_win = 1'b0;
    run_fade(2'd1, 2'd2, 0, "play_to_result");
    vectors++;
    if (result_win !== 1'b1 || dbg_state !== S_RESULT) begin
      miscompares++;
      $display("FAIL result_entry: got win=%0b state=%0d want 1 S_RESULT", result_win, dbg_state);
    end
  endtask

  task automatic test_result_hold();
    start = 1'b0;
    wait_tick("hold1");
    wait_tick("hold2");
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0 || screen_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL early_start_dropped: got busy=%0b sel=%0d want 0,2", busy, screen_sel);
    end
    wait_tick("hold3");
    vectors++;
    if (busy !== 1'b0 || dbg_state !== S_RESULT) begin
      miscompares++;
      $display("FAIL hold3_still_result: got busy=%0b state=%0d want 0 S_RESULT", busy, dbg_state);
    end
    wait_tick("hold4");
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_expired_start: got busy=%0b want 1", busy);
    end
    run_fade(2'd2, 2'd0, 0, "result_to_title");
    vectors++;
    if (dbg_state !== S_TITLE || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_title: got state=%0d busy=%0b want S_TITLE 0", dbg_state, busy);
    end
  endtask

  task automatic test_reset_mid_fade();
    start = 1'b1;
    step();
    start = 1'b0;
    rst_seen = 0;
    for (int k = 1; k <= 11; k++) begin
      wait_tick("mid_fade");
      vectors++;
      if (fade_level !== 5'(16 - k)) begin
        miscompares++;
        $display("FAIL mid_fade level tick %0d: got %0d want %0d", k, fade_level, 16 - k);
      end
      if (k == 8) begin
        title_rgb = 12'hF84;
        step();
        vectors++;
        if ({red, green, blue} !== 12'h742) begin
          miscompares++;
          $display("FAIL half_level_rgb: got %h want 742", {red, green, blue});
        end
      end
    end
    Reset = 1'b1;
    step();
    vectors++;
    if (screen_sel !== 2'd0 || fade_level !== 5'd16 || busy !== 1'b0 ||
        {red, green, blue} !== 12'h000 || rst_seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_fade: got sel=%0d lvl=%0d busy=%0b rgb=%h rst_pulses=%0d want 0,16,0,000,0",
               screen_sel, fade_level, busy, {red, green, blue}, rst_seen);
    end
    Reset = 1'b0;
    repeat (5) step();
    vectors++;
    if (dbg_state !== S_TITLE || fade_level !== 5'd16 || rst_seen !== 0) begin
      miscompares++;
      $display("FAIL after_reset_release: got state=%0d lvl=%0d rst_pulses=%0d want S_TITLE,16,0",
               dbg_state, fade_level, rst_seen);
    end
  endtask

  initial begin
    test_reset();
    test_fade_to_play();
    test_play_to_result();
    test_result_hold();
    test_reset_mid_fade();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
